// File: rtl/osc_pkg.sv
// Shared types for the NCO: waveform mode encoding and reset-duty helper.
package osc_pkg;

  typedef enum logic [1:0] {
    SQUARE    = 2'd0,
    SAW       = 2'd1,
    TRI       = 2'd2,
    RAMP_DOWN = 2'd3
  } osc_mode_e;

  localparam int unsigned OSC_PHASE_W_DEFAULT = 32;
  localparam int unsigned OSC_OUT_W_DEFAULT   = 16;

  // Reset duty is half scale: only the phase MSB set.
  function automatic logic [63:0] osc_default_duty(input int unsigned phase_w);
    return 64'd1 << (phase_w - 1);
  endfunction

endpackage

// File: rtl/osc_shaper.sv
// Registered wave shaper: maps phase/mode/duty to an OUT_W sample and a square tap.
// One cycle from phase register to outputs; stage freezes while en_i is low.
module osc_shaper
  import osc_pkg::*;
#(
  parameter int unsigned PHASE_W = OSC_PHASE_W_DEFAULT,
  parameter int unsigned OUT_W   = OSC_OUT_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] phase_i,
  input  osc_mode_e          mode_i,
  input  logic [PHASE_W-1:0] duty_i,
  output logic [OUT_W-1:0]   wave_o,
  output logic               sq_o
);

  logic [OUT_W-1:0] saw_s;
  logic [OUT_W-1:0] tri_s;
  logic [OUT_W-1:0] wave_d, wave_q;
  logic             sq_d, sq_q;

  always_comb begin
    saw_s = phase_i[PHASE_W-1 -: OUT_W];
    // Triangle uses one bit less of phase so it climbs twice as fast, then folds.
    tri_s = phase_i[PHASE_W-2 -: OUT_W];
    sq_d  = (phase_i < duty_i);
    wave_d = '0;
    case (mode_i)
      SQUARE:    wave_d = sq_d ? '1 : '0;
      SAW:       wave_d = saw_s;
      TRI:       wave_d = phase_i[PHASE_W-1] ? ~tri_s : tri_s;
      RAMP_DOWN: wave_d = ~saw_s;
      default:   wave_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wave_q <= '0;
      sq_q   <= 1'b0;
    end else if (en_i) begin
      wave_q <= wave_d;
      sq_q   <= sq_d;
    end
  end

  assign wave_o = wave_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/osc_nco.sv
// NCO top: phase accumulator, shadowed config applied only at wrap (or when stopped).
// Optional hard sync on sync_in_i when OSC_SYNC_EN is defined; cfg_ready_o low while a cfg is pending.
module osc_nco
  import osc_pkg::*;
#(
  parameter int unsigned PHASE_W = OSC_PHASE_W_DEFAULT,
  parameter int unsigned OUT_W   = OSC_OUT_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
`ifdef OSC_SYNC_EN
  input  logic               sync_in_i,
`endif
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [1:0]         cfg_mode_i,
  input  logic [PHASE_W-1:0] cfg_phase_inc_i,
  input  logic [PHASE_W-1:0] cfg_duty_i,
  output logic [OUT_W-1:0]   wave_out_o,
  output logic               sq_out_o,
  output logic               wrap_o
);

  localparam logic [PHASE_W-1:0] DutyRst = PHASE_W'(osc_default_duty(PHASE_W));

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [PHASE_W-1:0] duty_q, duty_d;
  osc_mode_e          mode_q, mode_d;

  logic [PHASE_W-1:0] sh_inc_q, sh_inc_d;
  logic [PHASE_W-1:0] sh_duty_q, sh_duty_d;
  osc_mode_e          sh_mode_q, sh_mode_d;

  logic               pend_q, pend_d;
  logic               wrap_q, wrap_d;

  logic [PHASE_W:0]   sum;
  logic               restart;
  logic               accept;
  logic               apply;

  always_comb begin
    sum = {1'b0, phase_q} + {1'b0, inc_q};
`ifdef OSC_SYNC_EN
    restart = enable_i & (sum[PHASE_W] | sync_in_i);
`else
    restart = enable_i & sum[PHASE_W];
`endif
    accept = cfg_valid_i & ~pend_q;
    // A stopped oscillator never wraps, so take the new setting straight away.
    apply  = pend_q & (restart | (inc_q == '0));

    phase_d = phase_q;
    if (enable_i) begin
      phase_d = sum[PHASE_W-1:0];
`ifdef OSC_SYNC_EN
      if (sync_in_i) phase_d = '0;
`endif
    end
    wrap_d = restart;

    mode_d = mode_q;
    inc_d  = inc_q;
    duty_d = duty_q;
    if (apply) begin
      mode_d = sh_mode_q;
      inc_d  = sh_inc_q;
      duty_d = sh_duty_q;
    end

    sh_mode_d = sh_mode_q;
    sh_inc_d  = sh_inc_q;
    sh_duty_d = sh_duty_q;
    if (accept) begin
      sh_mode_d = osc_mode_e'(cfg_mode_i);
      sh_inc_d  = cfg_phase_inc_i;
      sh_duty_d = cfg_duty_i;
    end

    pend_d = pend_q;
    if (apply)       pend_d = 1'b0;
    else if (accept) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q   <= '0;
      inc_q     <= '0;
      duty_q    <= DutyRst;
      mode_q    <= SQUARE;
      sh_inc_q  <= '0;
      sh_duty_q <= '0;
      sh_mode_q <= SQUARE;
      pend_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      duty_q    <= duty_d;
      mode_q    <= mode_d;
      sh_inc_q  <= sh_inc_d;
      sh_duty_q <= sh_duty_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      wrap_q    <= wrap_d;
    end
  end

  osc_shaper #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_shaper (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (enable_i),
    .phase_i (phase_q),
    .mode_i  (mode_q),
    .duty_i  (duty_q),
    .wave_o  (wave_out_o),
    .sq_o    (sq_out_o)
  );

  assign cfg_ready_o = ~pend_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_osc_nco.sv
// Bench for osc_nco: directed scenarios with constant expectations plus a random run against a cycle model.
module tb_osc_nco;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic [1:0]  cfg_mode_i = 2'd0;
  logic [31:0] cfg_phase_inc_i = '0;
  logic [31:0] cfg_duty_i = '0;
`ifdef OSC_SYNC_EN
  logic        sync_in_i = 1'b0;
`endif
  logic        cfg_ready_o;
  logic [15:0] wave_out_o;
  logic        sq_out_o;
  logic        wrap_o;

  int total = 0;
  int bad = 0;

  // Reference model state
  longint unsigned m_phase, m_inc, m_duty, s_inc, s_duty;
  int              m_mode, s_mode, m_wave;
  bit              m_pend, m_sq, m_wrap;

  always #5 clk_i = ~clk_i;

  osc_nco #(.PHASE_W(32), .OUT_W(16)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .enable_i        (enable_i),
`ifdef OSC_SYNC_EN
    .sync_in_i       (sync_in_i),
`endif
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .cfg_mode_i      (cfg_mode_i),
    .cfg_phase_inc_i (cfg_phase_inc_i),
    .cfg_duty_i      (cfg_duty_i),
    .wave_out_o      (wave_out_o),
    .sq_out_o        (sq_out_o),
    .wrap_o          (wrap_o)
  );

  function automatic int shape(int mode, longint unsigned ph, longint unsigned duty);
    longint unsigned t;
    t = (ph >> 15) & 64'hFFFF;
    case (mode)
      0:       return (ph < duty) ? 65535 : 0;
      1:       return int'(ph >> 16);
      2:       return (ph < 64'h8000_0000) ? int'(t) : 65535 - int'(t);
      default: return 65535 - int'(ph >> 16);
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_inc = 0; m_duty = 64'h8000_0000; m_mode = 0;
    s_inc = 0; s_duty = 0; s_mode = 0;
    m_pend = 0; m_wave = 0; m_sq = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    longint unsigned nxt;
    bit sync_b, restart, acc, app;
    sync_b = 1'b0;
`ifdef OSC_SYNC_EN
    sync_b = sync_in_i;
`endif
    nxt = m_phase + m_inc;
    restart = enable_i && ((nxt >= 64'h1_0000_0000) || sync_b);
    acc = cfg_valid_i && !m_pend;
    app = m_pend && (restart || m_inc == 0);
    if (enable_i) begin
      m_wave  = shape(m_mode, m_phase, m_duty);
      m_sq    = (m_phase < m_duty);
      m_phase = sync_b ? 0 : (nxt % 64'h1_0000_0000);
    end
    m_wrap = restart;
    if (app) begin
      m_mode = s_mode; m_inc = s_inc; m_duty = s_duty; m_pend = 0;
    end
    if (acc) begin
      s_mode = int'(cfg_mode_i); s_inc = cfg_phase_inc_i; s_duty = cfg_duty_i; m_pend = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; enable_i = 1'b0; cfg_valid_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic send_cfg(input logic [1:0] mode, input logic [31:0] inc, input logic [31:0] duty);
    cfg_valid_i = 1'b1; cfg_mode_i = mode; cfg_phase_inc_i = inc; cfg_duty_i = duty;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (wave_out_o !== 16'h0) begin bad++; $display("FAIL reset_wave got=%h exp=0000", wave_out_o); end
    total++; if (sq_out_o !== 1'b0) begin bad++; $display("FAIL reset_sq got=%b exp=0", sq_out_o); end
    total++; if (wrap_o !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap_o); end
    total++; if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cfg_ready_o); end
  endtask

  task automatic test_stopped_start();
    logic [15:0] exp_w [4] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    enable_i = 1'b1;
    send_cfg(2'd1, 32'h4000_0000, 32'h8000_0000);
    total++; if (cfg_ready_o !== 1'b0) begin bad++; $display("FAIL start_ready_low got=%b exp=0", cfg_ready_o); end
    tick();
    total++; if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL start_ready_back got=%b exp=1", cfg_ready_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (wave_out_o !== exp_w[k]) begin bad++; $display("FAIL start_wave k=%0d got=%h exp=%h", k, wave_out_o, exp_w[k]); end
      total++; if (wrap_o !== (k == 3)) begin bad++; $display("FAIL start_wrap k=%0d got=%b exp=%b", k, wrap_o, k == 3); end
    end
  endtask

  task automatic test_wrap_update();
    logic [15:0] exp_w [6] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h8000};
    logic        exp_r [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    send_cfg(2'd1, 32'h8000_0000, 32'h8000_0000);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      total++; if (wave_out_o !== exp_w[k]) begin bad++; $display("FAIL upd_wave k=%0d got=%h exp=%h", k, wave_out_o, exp_w[k]); end
      total++; if (cfg_ready_o !== exp_r[k]) begin bad++; $display("FAIL upd_ready k=%0d got=%b exp=%b", k, cfg_ready_o, exp_r[k]); end
    end
  endtask

  task automatic test_triangle();
    logic [15:0] exp_w [4] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF};
    do_reset();
    enable_i = 1'b1;
    send_cfg(2'd2, 32'h4000_0000, 32'h8000_0000);
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (wave_out_o !== exp_w[k % 4]) begin bad++; $display("FAIL tri k=%0d got=%h exp=%h", k, wave_out_o, exp_w[k % 4]); end
    end
  endtask

  task automatic test_duty();
    logic [15:0] pat;
    int hi, mism;
    do_reset();
    enable_i = 1'b1;
    send_cfg(2'd0, 32'h1000_0000, 32'h4000_0000);
    tick();
    pat = '0; mism = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      pat = {pat[14:0], sq_out_o};
      if (wave_out_o !== (sq_out_o ? 16'hFFFF : 16'h0000)) mism++;
    end
    total++; if (pat !== 16'hF000) begin bad++; $display("FAIL duty_pattern got=%h exp=f000", pat); end
    total++; if (mism !== 0) begin bad++; $display("FAIL duty_wave_vs_sq got=%0d exp=0", mism); end
    send_cfg(2'd0, 32'h1000_0000, 32'h0);
    repeat (16) tick();
    hi = 0; mism = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (sq_out_o !== 1'b0) hi++;
      if (wave_out_o !== 16'h0) mism++;
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL duty0_sq got=%0d exp=0", hi); end
    total++; if (mism !== 0) begin bad++; $display("FAIL duty0_wave got=%0d exp=0", mism); end
  endtask

  task automatic test_enable_hold();
    do_reset();
    enable_i = 1'b1;
    send_cfg(2'd1, 32'h1000_0000, 32'h8000_0000);
    repeat (3) tick();
    enable_i = 1'b0;
    send_cfg(2'd3, 32'h2000_0000, 32'h8000_0000);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      total++;
      if ({wave_out_o, sq_out_o, wrap_o, cfg_ready_o} !== {16'h1000, 1'b1, 1'b0, 1'b0}) begin
        bad++; $display("FAIL hold k=%0d got=%h/%b/%b/%b exp=1000/1/0/0", k, wave_out_o, sq_out_o, wrap_o, cfg_ready_o);
      end
    end
    enable_i = 1'b1;
    repeat (13) tick();
    total++; if (cfg_ready_o !== 1'b0) begin bad++; $display("FAIL hold_pending got=%b exp=0", cfg_ready_o); end
    tick();
    total++;
    if ({wave_out_o, wrap_o, cfg_ready_o} !== {16'hF000, 1'b1, 1'b1}) begin
      bad++; $display("FAIL hold_apply got=%h/%b/%b exp=f000/1/1", wave_out_o, wrap_o, cfg_ready_o);
    end
    tick();
    total++; if (wave_out_o !== 16'hFFFF) begin bad++; $display("FAIL hold_newmode got=%h exp=ffff", wave_out_o); end
    tick();
    total++; if (wave_out_o !== 16'hDFFF) begin bad++; $display("FAIL hold_newinc got=%h exp=dfff", wave_out_o); end
  endtask

  task automatic test_reset_mid();
    send_cfg(2'd1, 32'h0400_0000, 32'h0);
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    total++;
    if ({wave_out_o, sq_out_o, wrap_o, cfg_ready_o} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL midreset got=%h/%b/%b/%b exp=0000/0/0/1", wave_out_o, sq_out_o, wrap_o, cfg_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({wave_out_o, sq_out_o, wrap_o, cfg_ready_o} !== {16'hFFFF, 1'b1, 1'b0, 1'b1}) begin
        bad++; $display("FAIL midreset_after k=%0d got=%h/%b/%b/%b exp=ffff/1/0/1", k, wave_out_o, sq_out_o, wrap_o, cfg_ready_o);
      end
    end
  endtask

`ifdef OSC_SYNC_EN
  task automatic test_sync();
    do_reset();
    enable_i = 1'b1;
    send_cfg(2'd1, 32'h1000_0000, 32'h8000_0000);
    repeat (12) tick();
    send_cfg(2'd3, 32'h2000_0000, 32'h8000_0000);
    sync_in_i = 1'b1;
    tick();
    sync_in_i = 1'b0;
    total++; if (wrap_o !== 1'b1) begin bad++; $display("FAIL sync_wrap got=%b exp=1", wrap_o); end
    tick();
    total++;
    if ({wave_out_o, cfg_ready_o} !== {16'hFFFF, 1'b1}) begin
      bad++; $display("FAIL sync_apply got=%h/%b exp=ffff/1", wave_out_o, cfg_ready_o);
    end
    tick();
    total++; if (wave_out_o !== 16'hDFFF) begin bad++; $display("FAIL sync_newinc got=%h exp=dfff", wave_out_o); end
  endtask
`endif

  task automatic test_random();
    logic [18:0] exp_v;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      enable_i    = ($urandom_range(0, 3) != 0);
      cfg_valid_i = ($urandom_range(0, 2) == 0);
      cfg_mode_i  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       cfg_phase_inc_i = 32'h0;
        1:       cfg_phase_inc_i = 32'h4000_0000;
        2:       cfg_phase_inc_i = 32'($urandom);
        default: cfg_phase_inc_i = 32'($urandom) | 32'h8000_0000;
      endcase
      cfg_duty_i = 32'($urandom);
`ifdef OSC_SYNC_EN
      sync_in_i = ($urandom_range(0, 15) == 0);
`endif
      tick();
      exp_v = {m_wave[15:0], m_sq, m_wrap, ~m_pend};
      total++;
      if ({wave_out_o, sq_out_o, wrap_o, cfg_ready_o} !== exp_v) begin
        bad++; $display("FAIL random c=%0d got=%h exp=%h", c, {wave_out_o, sq_out_o, wrap_o, cfg_ready_o}, exp_v);
      end
    end
    cfg_valid_i = 1'b0;
`ifdef OSC_SYNC_EN
    sync_in_i = 1'b0;
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stopped_start();
    test_wrap_update();
    test_triangle();
    test_duty();
    test_enable_hold();
    test_reset_mid();
`ifdef OSC_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/osc_nco.md
# osc_nco

Parametrised numerically-controlled oscillator for the synth datapath, the successor to the single-bit square oscillator. A PHASE_W phase accumulator drives a registered wave shaper producing square with programmable duty, saw, triangle or ramp-down at OUT_W bits, plus a 1-bit square tap. New frequency, duty and mode settings arrive over a valid/ready port and are applied only at phase wrap, so period changes never glitch.

## Interface
- PHASE_W, 32, phase accumulator width.
- OUT_W, 16, wave sample width, unsigned; must satisfy OUT_W <= PHASE_W-1.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  advance phase when high; hold everything when low.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
- cfg_mode  in  2  0 SQUARE, 1 SAW, 2 TRI, 3 RAMP_DOWN.
- cfg_phase_inc  in  PHASE_W  phase increment per enabled cycle.
- cfg_duty  in  PHASE_W  square threshold.
- wave_out  out  OUT_W  shaped sample.
- sq_out  out  1  square tap, phase < duty, any mode.
- wrap  out  1  one-cycle pulse on phase wrap.
- sync_in  in  1  hard sync; present only with OSC_SYNC_EN.

## Operation
- Active regs mode_r, inc_r, duty_r. Reset: SQUARE, 0, 2^(PHASE_W-1).
- Shadow regs plus pending flag. cfg_ready = !pending. An accepted beat loads the shadow regs and sets pending.
- Pending is applied, copying shadow to active and clearing pending, when either:
  - enable && the phase add carries out, or
  - inc_r == 0 (oscillator stopped); applied on the cycle after acceptance regardless of enable.
- Phase: when enable, phase <= phase + inc_r, modulo 2^PHASE_W, using the pre-update inc_r. Carry out registers wrap=1 for that one cycle. The new inc_r is first used on the following add.
- enable low: phase, wrap=0, pending and outputs all hold. No wrap-based apply occurs.
- Shaper, registered from phase and mode_r of the previous cycle; S = phase[PHASE_W-1 -: OUT_W]:
  - SQUARE: all ones if phase < duty_r, else 0.
  - SAW: S.
  - TRI: phase[PHASE_W-2 -: OUT_W] when MSB = 0, its bitwise inverse when MSB = 1.
  - RAMP_DOWN: ~S.
  - sq_out = (phase < duty_r). With duty 0 it is constant low.
- Reset mid-operation: all state returns to reset values immediately and any pending cfg is discarded.

## Timing
- Outputs reset: wave_out 0, sq_out 0, wrap 0. cfg_ready is 1 out of reset.
- Latency: phase register to wave_out/sq_out is 1 cycle. wrap is aligned with the phase register, one cycle ahead of the sample of the new period.
- Handshake: cfg_ready deasserts the cycle after acceptance and reasserts the cycle after apply. Back-to-back acceptance is impossible by construction.
- Simultaneous events: sync beats the add, and apply beats a new acceptance because ready is low.

## Configuration
- OSC_SYNC_EN defined:
  - sync_in port exists.
  - sync_in && enable sets phase <= 0, pulses wrap and applies any pending config, overriding the add.
- OSC_SYNC_EN undefined:
  - no sync_in port and no sync logic.
  - Phase is changed only by the add.

## Structure
- Package osc_pkg holds:
  - osc_mode_e enum (SQUARE, SAW, TRI, RAMP_DOWN).
  - localparam default-duty function of PHASE_W.
- Sub-module osc_shaper: registered phase/mode/duty to wave_out/sq_out stage. The top holds the accumulator, shadow regs and handshake.

## Test plan
All cases use PHASE_W=32, OUT_W=16.
- Stopped start: after reset, cfg inc=0x4000_0000, mode SAW, enable=1.
  - Applied the next cycle.
  - phase 0, 0x4000_0000, 0x8000_0000, 0xC000_0000, 0.
  - wave_out 0x0000, 0x4000, 0x8000, 0xC000 one cycle later.
  - wrap high only on the cycle phase returns to 0.
- Wrap-gated update: running inc 0x4000_0000, phase 0x4000_0000, accept inc 0x8000_0000.
  - cfg_ready low for 3 cycles.
  - Phase steps 0x8000_0000, 0xC000_0000, 0, then 0x8000_0000.
- Triangle: mode TRI, inc 0x4000_0000 gives wave_out 0x0000, 0x8000, 0xFFFF, 0x7FFF repeating.
- Duty: mode SQUARE, duty 0x4000_0000, inc 0x1000_0000.
  - sq_out and wave_out=0xFFFF for 4 of every 16 cycles.
  - Duty 0 gives constant 0.
- Enable/reset: enable low for 5 cycles with a pending cfg holds phase, outputs and pending, with no apply. rst low mid-period zeroes outputs asynchronously and drops pending.
- Sync (OSC_SYNC_EN): sync_in at phase 0xC000_0000 with cfg pending.
  - phase 0 and wrap=1 next cycle.
  - New config active and cfg_ready high the cycle after.
